// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline boundary register.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int DEF_LANES  = 32;
   localparam int DEF_LANE_W = 8;
   localparam int DEF_OPW    = 32;
   localparam int DEF_CNT_W  = 16;

   // An entry is {lane data, operand A, operand B}, moved as one unit.
   function automatic int entry_w(input int lanes, input int lane_w, input int opw);
      return lanes * lane_w + 2 * opw;
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake and data bus of one pipeline boundary.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = DEF_LANE_W,
   parameter int OPW    = DEF_OPW
);

   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*LANE_W-1:0] d;
   logic [OPW-1:0]          a;
   logic [OPW-1:0]          b;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*LANE_W-1:0] q;
   logic [OPW-1:0]          wire1;
   logic [OPW-1:0]          wire2;

   modport master (
      output in_valid, d, a, b, out_ready,
      input  in_ready, out_valid, q, wire1, wire2
   );

   modport slave (
      input  in_valid, d, a, b, out_ready,
      output in_ready, out_valid, q, wire1, wire2
   );

endinterface

// File: rtl/pipe_entry_reg.sv
// Width-parametrised entry register with load enable and async active-low clear.
module pipe_entry_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: the data register is reset so a freshly reset stage shows zeros, not X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = DEF_LANE_W,
   parameter int OPW    = DEF_OPW,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_skid_if.slave  bus,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int EW = entry_w(LANES, LANE_W, OPW);

   state_t        state;
   logic          in_fire;
   logic          out_fire;
   logic          main_en;
   logic          skid_en;
   logic [EW-1:0] in_entry;
   logic [EW-1:0] main_d;
   logic [EW-1:0] main_q;
   logic [EW-1:0] skid_q;

   // in_ready depends only on registered state, so no path from out_ready.
   assign bus.in_ready  = rst & (state != FULL);
   assign bus.out_valid = (state != EMPTY);
   assign in_fire       = bus.in_valid & bus.in_ready;
   assign out_fire      = bus.out_valid & bus.out_ready;
   assign in_entry      = {bus.d, bus.a, bus.b};
   assign occupancy     = state;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = in_entry;
      if (!flush) begin
         unique case (state)
            EMPTY: main_en = in_fire;
            ONE: begin
               main_en = in_fire & out_fire;
               skid_en = in_fire & ~out_fire;
            end
            FULL: begin
               main_en = out_fire;
               main_d  = skid_q;
            end
            default: ;
         endcase
      end
   end

   pipe_entry_reg #(.W(EW)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   pipe_entry_reg #(.W(EW)) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_entry),
      .q   (skid_q)
   );

   assign {bus.q, bus.wire1, bus.wire2} = main_q;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= EMPTY;
         stall_cnt <= '0;
      end else begin
         if (bus.out_valid && !bus.out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush) begin
            state <= EMPTY;
         end else begin
            unique case (state)
               EMPTY: if (in_fire) state <= ONE;
               ONE: begin
                  if (in_fire && !out_fire) begin
                     state <= FULL;
                  end else if (!in_fire && out_fire) begin
                     state <= EMPTY;
                  end
               end
               FULL: if (out_fire) state <= ONE;
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule
